logic_unit_seq: RTL

- Parametrised, multi-cycle bitwise logic unit. It is the successor of the fixed 32-bit combinational gate arrays.
- Computes AND/OR/XOR/NOR of two WIDTH-bit operands, SLICE bits per clock, under a start/busy/done handshake.
- Sits beside the ALU datapath. Lets the operand width scale without widening the per-cycle gate array.

---
 rtl/logic_unit_seq_pkg.sv | 23 ++
 rtl/logic_unit_seq_slice.sv | 36 +++
 rtl/logic_unit_seq.sv | 110 +++++++++++
 3 files changed

// File: rtl/logic_unit_seq_pkg.sv
// Shared encodings and helpers for the sequential bitwise logic unit.
// Operation and FSM state encodings live here so the top and slice agree on them.
package logic_unit_seq_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // A one-slice configuration still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/logic_unit_seq_slice.sv
// One SLICE-wide bitwise gate array: all four gate results per bit, picked by op.
module logic_slice
    import logic_unit_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [1:0]   op,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] z
);

    logic [W-1:0] and_w;
    logic [W-1:0] or_w;
    logic [W-1:0] xor_w;
    logic [W-1:0] nor_w;

    for (genvar i = 0; i < W; i++) begin : g_bit
        and u_and (and_w[i], x[i], y[i]);
        or  u_or  (or_w[i],  x[i], y[i]);
        xor u_xor (xor_w[i], x[i], y[i]);
        nor u_nor (nor_w[i], x[i], y[i]);
    end

    always_comb begin
        z = and_w;
        case (op_t'(op))
            OP_AND:  z = and_w;
            OP_OR:   z = or_w;
            OP_XOR:  z = xor_w;
            OP_NOR:  z = nor_w;
            default: z = and_w;
        endcase
    end

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: processes SLICE bits of a WIDTH-bit operation per
// clock under a start/busy/done handshake, publishing result and zero only on completion.
module logic_unit_seq
    import logic_unit_seq_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int SLICE = 8,
    localparam int N     = WIDTH / SLICE,
    localparam int IDXW  = idx_width(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    state_t           state;
    state_t           state_next;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_l;
    logic [WIDTH-1:0] b_l;
    op_t              op_l;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [SLICE-1:0] x_sl;
    logic [SLICE-1:0] y_sl;
    logic [SLICE-1:0] z_sl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (idx == LAST) state_next = S_DONE;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign x_sl = SLICE'(a_l >> (int'(idx) * SLICE));
    assign y_sl = SLICE'(b_l >> (int'(idx) * SLICE));

    logic_slice #(.W(SLICE)) u_slice (
        .op (op_l),
        .x  (x_sl),
        .y  (y_sl),
        .z  (z_sl)
    );

    // The completed word includes the slice being written this edge, so result
    // and zero are loaded from the merged value rather than the old accumulator.
    always_comb begin
        acc_next = acc;
        for (int i = 0; i < N; i++) begin
            if (idx == IDXW'(i)) acc_next[i*SLICE +: SLICE] = z_sl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            a_l    <= '0;
            b_l    <= '0;
            op_l   <= OP_AND;
            acc    <= '0;
            result <= '0;
            zero   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_l  <= a;
                        b_l  <= b;
                        op_l <= op_t'(op);
                        idx  <= '0;
                    end
                end
                S_RUN: begin
                    acc <= acc_next;
                    if (idx == LAST) begin
                        result <= acc_next;
                        zero   <= (acc_next == '0);
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule
